// File: rtl/dma_pkg.sv
// Shared state encoding and helpers for the DMA transfer sequencer.
// Channel vectors handed to onehot_to_idx are zero-extended to MAX_CH bits.
package dma_pkg;

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_RSP, WR, RELEASE} dma_seq_state_e;

   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned DEF_DW        = 32;
   localparam int unsigned ADDR_STEP     = DEF_DW / BITS_PER_BYTE;
   localparam int unsigned MAX_CH        = 32;

   function automatic int unsigned addr_step(input int unsigned dw);
      return dw / BITS_PER_BYTE;
   endfunction

   // Lowest set bit wins, so a malformed multi-hot grant still picks one channel.
   function automatic int unsigned onehot_to_idx(input logic [MAX_CH-1:0] vec);
      int unsigned idx;
      idx = 0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (vec[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dma_ch_ctx.sv
// Per-channel context: src/dst/remaining, busy and yield flags, start latch, done pulse.
// Updates one cycle after a start or advance strobe; a start while busy is dropped.
module dma_ch_ctx
   import dma_pkg::*;
#(
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned LENW = 16
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            start,
   input  logic [AW-1:0]   src_in,
   input  logic [AW-1:0]   dst_in,
   input  logic [LENW-1:0] len_in,
   input  logic            advance,
   input  logic            set_yield,
   input  logic            clr_yield,
   output logic [AW-1:0]   src,
   output logic [AW-1:0]   dst,
   output logic            busy,
   output logic            yield,
   output logic            last,
   output logic            done
);

   localparam int unsigned STEP = addr_step(DW);

   logic [LENW-1:0] remaining;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         yield     <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (advance) begin
               src       <= src + AW'(STEP);
               dst       <= dst + AW'(STEP);
               remaining <= remaining - LENW'(1);
               if (remaining == LENW'(1)) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
         end else if (start) begin
            // Zero-length jobs complete immediately without ever requesting.
            if (len_in != '0) begin
               src       <= src_in;
               dst       <= dst_in;
               remaining <= len_in;
               busy      <= 1'b1;
            end else begin
               done <= 1'b1;
            end
         end
         if (set_yield) begin
            yield <= 1'b1;
         end else if (clr_yield) begin
            yield <= 1'b0;
         end
      end
   end

   assign last = (remaining == LENW'(1));

endmodule

// File: rtl/dma_xfer_sequencer.sv
// Moves one word at a time (read then write) for the granted channel; grant to rd_valid is 1 cycle.
// Valid is held with stable addr/data until ready; req drops after QUANTUM words or completion.
module dma_xfer_sequencer
   import dma_pkg::*;
#(
   parameter int unsigned DMA_CH  = 8,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned LENW    = 16,
   parameter int unsigned QUANTUM = 4
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic [DMA_CH-1:0]      start_i,
   input  logic [DMA_CH*AW-1:0]   src_addr_i,
   input  logic [DMA_CH*AW-1:0]   dst_addr_i,
   input  logic [DMA_CH*LENW-1:0] len_i,
   output logic [DMA_CH-1:0]      req_o,
   input  logic [DMA_CH-1:0]      grant_i,
   output logic                   rd_valid_o,
   output logic [AW-1:0]          rd_addr_o,
   input  logic                   rd_ready_i,
   input  logic                   rd_rvalid_i,
   input  logic [DW-1:0]          rd_rdata_i,
   output logic                   wr_valid_o,
   output logic [AW-1:0]          wr_addr_o,
   output logic [DW-1:0]          wr_data_o,
   input  logic                   wr_ready_i,
   output logic [DMA_CH-1:0]      busy_o,
   output logic [DMA_CH-1:0]      done_o
);

   localparam int unsigned CHW = (DMA_CH > 1) ? $clog2(DMA_CH) : 1;
   localparam int unsigned QW  = $clog2(QUANTUM + 1);

   dma_seq_state_e state, state_nxt;
   logic [CHW-1:0] cur_ch, cur_ch_nxt, grant_idx;
   logic [QW-1:0]  qcnt, qcnt_nxt;
   logic [DW-1:0]  data_q;

   logic [DMA_CH-1:0]         advance, set_yield, clr_yield;
   logic [DMA_CH-1:0]         ctx_busy, ctx_yield, ctx_last;
   logic [DMA_CH-1:0][AW-1:0] ctx_src, ctx_dst;

   assign grant_idx = CHW'(onehot_to_idx(MAX_CH'(grant_i)));

   for (genvar g = 0; g < DMA_CH; g++) begin : g_ctx
      dma_ch_ctx #(.AW(AW), .DW(DW), .LENW(LENW)) u_ctx (
         .clk_i     (clk_i),
         .rstn_i    (rstn_i),
         .start     (start_i[g]),
         .src_in    (src_addr_i[g*AW +: AW]),
         .dst_in    (dst_addr_i[g*AW +: AW]),
         .len_in    (len_i[g*LENW +: LENW]),
         .advance   (advance[g]),
         .set_yield (set_yield[g]),
         .clr_yield (clr_yield[g]),
         .src       (ctx_src[g]),
         .dst       (ctx_dst[g]),
         .busy      (ctx_busy[g]),
         .yield     (ctx_yield[g]),
         .last      (ctx_last[g]),
         .done      (done_o[g])
      );
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state  <= IDLE;
         cur_ch <= '0;
         qcnt   <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         cur_ch <= cur_ch_nxt;
         qcnt   <= qcnt_nxt;
         if (state == RD_RSP && rd_rvalid_i) data_q <= rd_rdata_i;
      end
   end

   always_comb begin
      state_nxt  = state;
      cur_ch_nxt = cur_ch;
      qcnt_nxt   = qcnt;
      advance    = '0;
      set_yield  = '0;
      clr_yield  = '0;
      case (state)
         IDLE: begin
            if (grant_i != '0 && ctx_busy[grant_idx]) begin
               state_nxt  = RD_CMD;
               cur_ch_nxt = grant_idx;
               qcnt_nxt   = '0;
            end
         end
         RD_CMD: if (rd_ready_i) state_nxt = RD_RSP;
         RD_RSP: if (rd_rvalid_i) state_nxt = WR;
         WR: begin
            if (wr_ready_i) begin
               advance[cur_ch] = 1'b1;
               qcnt_nxt        = qcnt + QW'(1);
               // Completion takes precedence over a quantum yield on the same word.
               if (ctx_last[cur_ch]) begin
                  state_nxt = RELEASE;
               end else if (qcnt + QW'(1) == QW'(QUANTUM)) begin
                  set_yield[cur_ch] = 1'b1;
                  state_nxt         = RELEASE;
               end else begin
                  state_nxt = RD_CMD;
               end
            end
         end
         RELEASE: begin
            if (grant_i == '0) begin
               clr_yield[cur_ch] = 1'b1;
               state_nxt         = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_o      = ctx_busy & ~ctx_yield;
   assign busy_o     = ctx_busy;
   assign rd_valid_o = (state == RD_CMD);
   assign rd_addr_o  = rd_valid_o ? ctx_src[cur_ch] : '0;
   assign wr_valid_o = (state == WR);
   assign wr_addr_o  = wr_valid_o ? ctx_dst[cur_ch] : '0;
   assign wr_data_o  = wr_valid_o ? data_q : '0;

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Bench for dma_xfer_sequencer: lock-until-release arbiter, randomized memory responder,
// and an address-keyed scoreboard of the reads and writes every started job must produce.
module tb_dma_xfer_sequencer;
   localparam int DMA_CH = 8, AW = 32, DW = 32, LENW = 16, QUANTUM = 4;

   logic                   clk_i = 1'b0;
   logic                   rstn_i;
   logic [DMA_CH-1:0]      start_i, grant_i, req_o, busy_o, done_o;
   logic [DMA_CH*AW-1:0]   src_addr_i, dst_addr_i;
   logic [DMA_CH*LENW-1:0] len_i;
   logic                   rd_valid_o, rd_ready_i, rd_rvalid_i, wr_valid_o, wr_ready_i;
   logic [AW-1:0]          rd_addr_o, wr_addr_o;
   logic [DW-1:0]          rd_rdata_i, wr_data_o;

   int tests = 0, fails = 0;
   logic [31:0] salt;
   logic [31:0] exp_wr [logic [31:0]];
   int          exp_rd [logic [31:0]];
   int done_cnt [DMA_CH], done_wr [DMA_CH], grant_cnt [DMA_CH], yield_cnt [DMA_CH];
   logic [DMA_CH-1:0] req_seen, prev_req;
   int rd_count = 0, wr_count = 0;
   int yield_wr [$];
   logic [31:0] rd_log [$];
   int rd_min, rd_max, wr_min, wr_max, rsp_min, rsp_max;
   bit rd_seen, wr_seen, rsp_pending;
   int rd_wait, wr_wait, rsp_wait;
   logic [31:0] rd_hold, wr_hold_a, wr_hold_d, rsp_addr;

   always #5 clk_i = ~clk_i;

   dma_xfer_sequencer #(.DMA_CH(DMA_CH), .AW(AW), .DW(DW), .LENW(LENW), .QUANTUM(QUANTUM)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .src_addr_i(src_addr_i),
      .dst_addr_i(dst_addr_i), .len_i(len_i), .req_o(req_o), .grant_i(grant_i),
      .rd_valid_o(rd_valid_o), .rd_addr_o(rd_addr_o), .rd_ready_i(rd_ready_i),
      .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i), .wr_valid_o(wr_valid_o),
      .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
      .busy_o(busy_o), .done_o(done_o));

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B9) ^ salt;
   endfunction

   // Arbiter, memory responder and monitors, all evaluated on the falling edge.
   initial begin
      grant_i = '0; rd_ready_i = 0; rd_rvalid_i = 0; rd_rdata_i = '0; wr_ready_i = 0;
      rd_seen = 0; wr_seen = 0; rsp_pending = 0; prev_req = '0; req_seen = '0;
      for (int i = 0; i < DMA_CH; i++) begin
         done_cnt[i] = 0; done_wr[i] = 0; grant_cnt[i] = 0; yield_cnt[i] = 0;
      end
      forever begin
         @(negedge clk_i);
         if (!rstn_i) begin
            grant_i = '0; rd_ready_i = 0; rd_rvalid_i = 0; wr_ready_i = 0;
            rd_seen = 0; wr_seen = 0; rsp_pending = 0; prev_req = '0;
            continue;
         end
         for (int i = 0; i < DMA_CH; i++) begin
            if (done_o[i]) begin done_cnt[i]++; done_wr[i] = wr_count; end
            if (req_o[i]) req_seen[i] = 1'b1;
            if (prev_req[i] && !req_o[i] && busy_o[i]) begin
               yield_cnt[i]++; yield_wr.push_back(wr_count);
            end
         end
         prev_req = req_o;
         if (grant_i != '0) begin
            if ((grant_i & req_o) == '0) grant_i = '0;
         end else if (req_o != '0) begin
            grant_i = req_o & (~req_o + DMA_CH'(1));
            for (int i = 0; i < DMA_CH; i++) if (grant_i[i]) grant_cnt[i]++;
         end
         rd_rvalid_i = 0;
         if (rsp_pending) begin
            if (rsp_wait == 0) begin
               rd_rvalid_i = 1; rd_rdata_i = mem_word(rsp_addr); rsp_pending = 0;
            end else rsp_wait--;
         end
         rd_ready_i = 0;
         if (rd_valid_o) begin
            if (rd_seen) begin
               tests++;
               if (rd_addr_o !== rd_hold) begin
                  fails++; $display("FAIL rd_stable: addr %h, required held %h", rd_addr_o, rd_hold);
               end
            end else begin
               rd_seen = 1; rd_hold = rd_addr_o; rd_wait = $urandom_range(rd_max, rd_min);
            end
            if (rd_wait == 0) begin
               rd_ready_i = 1; rd_seen = 0; rd_count++; rd_log.push_back(rd_addr_o);
               tests++;
               if (!exp_rd.exists(rd_addr_o)) begin
                  fails++; $display("FAIL rd_unexpected: addr %h, required an address of a started job", rd_addr_o);
               end else exp_rd.delete(rd_addr_o);
               rsp_pending = 1; rsp_addr = rd_addr_o; rsp_wait = $urandom_range(rsp_max, rsp_min);
            end else rd_wait--;
         end else if (rd_seen) begin
            tests++; fails++; rd_seen = 0;
            $display("FAIL rd_withdrawn: rd_valid 0, required 1 until ready");
         end
         wr_ready_i = 0;
         if (wr_valid_o) begin
            if (wr_seen) begin
               tests++;
               if (wr_addr_o !== wr_hold_a || wr_data_o !== wr_hold_d) begin
                  fails++;
                  $display("FAIL wr_stable: addr/data %h/%h, required held %h/%h", wr_addr_o, wr_data_o, wr_hold_a, wr_hold_d);
               end
            end else begin
               wr_seen = 1; wr_hold_a = wr_addr_o; wr_hold_d = wr_data_o;
               wr_wait = $urandom_range(wr_max, wr_min);
            end
            if (wr_wait == 0) begin
               wr_ready_i = 1; wr_seen = 0; wr_count++;
               tests++;
               if (!exp_wr.exists(wr_addr_o)) begin
                  fails++; $display("FAIL wr_unexpected: addr %h, required an address of a started job", wr_addr_o);
               end else begin
                  if (wr_data_o !== exp_wr[wr_addr_o]) begin
                     fails++; $display("FAIL wr_data: addr %h data %h, required %h", wr_addr_o, wr_data_o, exp_wr[wr_addr_o]);
                  end
                  exp_wr.delete(wr_addr_o);
               end
            end else wr_wait--;
         end else if (wr_seen) begin
            tests++; fails++; wr_seen = 0;
            $display("FAIL wr_withdrawn: wr_valid 0, required 1 until ready");
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(negedge clk_i); #1; end
   endtask

   task automatic cfg(input int ch, input logic [31:0] s, input logic [31:0] d, input int len);
      src_addr_i[ch*AW +: AW]     = s;
      dst_addr_i[ch*AW +: AW]     = d;
      len_i[ch*LENW +: LENW]      = LENW'(len);
      for (int k = 0; k < len; k++) begin
         exp_rd[s + 32'(4*k)] = 1;
         exp_wr[d + 32'(4*k)] = mem_word(s + 32'(4*k));
      end
   endtask

   task automatic pulse(input logic [DMA_CH-1:0] m);
      start_i = m; tick(1); start_i = '0;
   endtask

   task automatic wait_done(input int ch, input int target, input int budget);
      int n = 0;
      while (done_cnt[ch] < target && n < budget) begin tick(1); n++; end
      tests++;
      if (done_cnt[ch] < target) begin
         fails++; $display("FAIL wait_done ch%0d: done count %0d, required %0d within %0d cycles", ch, done_cnt[ch], target, budget);
      end
   endtask

   task automatic check_sb(input string name);
      tests++;
      if (exp_wr.num() != 0 || exp_rd.num() != 0) begin
         fails++; $display("FAIL %s scoreboard: %0d writes %0d reads left, required 0/0", name, exp_wr.num(), exp_rd.num());
      end
   endtask

   task automatic test_reset();
      rstn_i = 0; tick(3);
      tests++;
      if ({req_o, busy_o, done_o, rd_valid_o, wr_valid_o} !== '0) begin
         fails++; $display("FAIL reset_ctl: %h, required 0", {req_o, busy_o, done_o, rd_valid_o, wr_valid_o});
      end
      tests++;
      if ({rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
         fails++; $display("FAIL reset_bus: %h, required 0", {rd_addr_o, wr_addr_o, wr_data_o});
      end
      rstn_i = 1; tick(2);
      tests++;
      if ({req_o, busy_o, done_o, rd_valid_o, wr_valid_o} !== '0) begin
         fails++; $display("FAIL post_reset_ctl: %h, required 0", {req_o, busy_o, done_o, rd_valid_o, wr_valid_o});
      end
   endtask

   task automatic test_basic();
      int w0 = wr_count;
      rd_log.delete();
      cfg(0, 32'h100, 32'h200, 3); pulse(8'h01);
      wait_done(0, 1, 300); tick(5);
      tests++;
      if (done_cnt[0] != 1) begin fails++; $display("FAIL basic_done: %0d pulses, required 1", done_cnt[0]); end
      tests++;
      if (wr_count - w0 != 3) begin fails++; $display("FAIL basic_writes: %0d, required 3", wr_count - w0); end
      tests++;
      if (rd_log.size() != 3) begin
         fails++; $display("FAIL basic_reads: %0d reads, required 3", rd_log.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (rd_log[k] !== 32'h100 + 32'(4*k)) begin
               fails++; $display("FAIL basic_rd_order[%0d]: %h, required %h", k, rd_log[k], 32'h100 + 32'(4*k));
            end
         end
      end
      check_sb("basic");
   endtask

   task automatic test_quantum();
      int w0 = wr_count, g0 = grant_cnt[1], d0 = done_cnt[1];
      yield_wr.delete();
      cfg(1, 32'h1000, 32'h2000, 10); pulse(8'h02);
      tick(2);
      // A second start while busy must not add any bus traffic.
      src_addr_i[1*AW +: AW] = 32'hDEAD_0000; len_i[1*LENW +: LENW] = 16'd5; pulse(8'h02);
      wait_done(1, d0 + 1, 600); tick(5);
      tests++;
      if (yield_wr.size() != 2) begin
         fails++; $display("FAIL quantum_yields: %0d, required 2", yield_wr.size());
      end else begin
         tests++;
         if (yield_wr[0] - w0 != QUANTUM || yield_wr[1] - w0 != 2 * QUANTUM) begin
            fails++; $display("FAIL quantum_points: after %0d/%0d words, required %0d/%0d", yield_wr[0] - w0, yield_wr[1] - w0, QUANTUM, 2 * QUANTUM);
         end
      end
      tests++;
      if (grant_cnt[1] - g0 != 3) begin fails++; $display("FAIL quantum_grants: %0d, required 3", grant_cnt[1] - g0); end
      tests++;
      if (done_wr[1] - w0 != 10 || wr_count - w0 != 10) begin
         fails++; $display("FAIL quantum_words: done after %0d, total %0d, required 10/10", done_wr[1] - w0, wr_count - w0);
      end
      tests++;
      if (done_cnt[1] != d0 + 1) begin fails++; $display("FAIL quantum_done: %0d, required %0d", done_cnt[1], d0 + 1); end
      check_sb("quantum");
   endtask

   task automatic test_zero_len();
      int r0 = rd_count, w0 = wr_count, d0 = done_cnt[2];
      req_seen[2] = 1'b0;
      cfg(2, 32'h3000, 32'h3100, 0); pulse(8'h04);
      tests++;
      if (done_o[2] !== 1'b1 || busy_o[2] !== 1'b0) begin
         fails++; $display("FAIL zero_next_cycle: done %b busy %b, required 1/0", done_o[2], busy_o[2]);
      end
      tick(10);
      tests++;
      if (done_cnt[2] != d0 + 1) begin fails++; $display("FAIL zero_done_count: %0d, required %0d", done_cnt[2], d0 + 1); end
      tests++;
      if (req_seen[2] !== 1'b0 || rd_count != r0 || wr_count != w0) begin
         fails++; $display("FAIL zero_no_activity: req %b rd %0d wr %0d, required 0/0/0", req_seen[2], rd_count - r0, wr_count - w0);
      end
   endtask

   task automatic test_stall();
      int r0 = rd_count, w0 = wr_count;
      rd_min = 5; rd_max = 5; wr_min = 5; wr_max = 5;
      cfg(4, 32'h5000, 32'h6000, 3); pulse(8'h10);
      wait_done(4, 1, 500); tick(3);
      rd_min = 0; rd_max = 2; wr_min = 0; wr_max = 2;
      tests++;
      if (rd_count - r0 != 3 || wr_count - w0 != 3) begin
         fails++; $display("FAIL stall_handshakes: rd %0d wr %0d, required 3/3", rd_count - r0, wr_count - w0);
      end
      check_sb("stall");
   endtask

   task automatic test_wrap();
      rd_log.delete();
      cfg(5, 32'hFFFF_FFFC, 32'h7000, 2); pulse(8'h20);
      wait_done(5, 1, 300); tick(3);
      tests++;
      if (rd_log.size() != 2) begin
         fails++; $display("FAIL wrap_reads: %0d, required 2", rd_log.size());
      end else begin
         tests++;
         if (rd_log[1] !== 32'h0000_0000) begin fails++; $display("FAIL wrap_addr: %h, required 00000000", rd_log[1]); end
      end
      check_sb("wrap");
   endtask

   task automatic test_reset_mid();
      int r0 = rd_count, n = 0, d3;
      rsp_min = 3; rsp_max = 3;
      cfg(3, 32'h9000, 32'hA000, 8); pulse(8'h08);
      while (rd_count == r0 && n < 200) begin tick(1); n++; end
      tests++;
      if (rd_count == r0) begin fails++; $display("FAIL midrst_read: no read, required one within 200 cycles"); end
      tick(1);
      rstn_i = 0; #1;
      tests++;
      if ({req_o, busy_o, done_o, rd_valid_o, wr_valid_o, rd_addr_o, wr_addr_o, wr_data_o} !== '0) begin
         fails++; $display("FAIL midrst_outputs: req %h busy %h done %h rdv %b wrv %b, required all 0", req_o, busy_o, done_o, rd_valid_o, wr_valid_o);
      end
      tick(3);
      exp_wr.delete(); exp_rd.delete();
      d3 = done_cnt[3];
      rstn_i = 1; rsp_min = 0; rsp_max = 2;
      tick(5);
      tests++;
      if (done_cnt[3] != d3 || busy_o !== '0) begin
         fails++; $display("FAIL midrst_no_done: done %0d busy %h, required %0d/00", done_cnt[3], busy_o, d3);
      end
      cfg(3, 32'hB000, 32'hC000, 2); pulse(8'h08);
      wait_done(3, d3 + 1, 300); tick(3);
      check_sb("reset_mid");
   endtask

   task automatic test_back_to_back();
      int tgt [DMA_CH];
      logic [DMA_CH-1:0] mask;
      for (int r = 0; r < 3; r++) begin
         mask = DMA_CH'($urandom_range(255, 1));
         for (int ch = 0; ch < DMA_CH; ch++) begin
            tgt[ch] = done_cnt[ch];
            if (mask[ch]) begin
               cfg(ch, 32'h4000_0000 + 32'(r << 20) + 32'(ch << 12) + 32'($urandom_range(63, 0) * 4),
                       32'h8000_0000 + 32'(r << 20) + 32'(ch << 12) + 32'($urandom_range(63, 0) * 4),
                       $urandom_range(9, 0));
               tgt[ch]++;
            end
         end
         pulse(mask);
         for (int ch = 0; ch < DMA_CH; ch++) if (mask[ch]) wait_done(ch, tgt[ch], 4000);
         tick(5);
         for (int ch = 0; ch < DMA_CH; ch++) begin
            tests++;
            if (done_cnt[ch] != tgt[ch]) begin
               fails++; $display("FAIL b2b_done r%0d ch%0d: %0d, required %0d", r, ch, done_cnt[ch], tgt[ch]);
            end
         end
         check_sb("back_to_back");
      end
   endtask

   initial begin
      salt = $urandom;
      rstn_i = 0; start_i = '0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
      rd_min = 0; rd_max = 2; wr_min = 0; wr_max = 2; rsp_min = 0; rsp_max = 2;
      test_reset();
      test_basic();
      test_quantum();
      test_zero_len();
      test_stall();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
